// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_monitor_if: run-control, event and read-port signals between the
// pipelined MIPS core (master) and the performance monitor (slave).
interface pipe_perf_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 3
);
  logic               halt;
  logic               go;
  logic [NUM_EVT-1:0] evt;
  logic               freeze;
  logic               clr;
  logic               snap;
  logic               rd_shadow;
  logic [SEL_W-1:0]   rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic [NUM_EVT:0]   ovf;
  logic               running;

  modport master (
    output halt, go, evt, freeze, clr, snap, rd_shadow, rd_sel,
    input  rd_data, ovf, running
  );

  modport slave (
    input  halt, go, evt, freeze, clr, snap, rd_shadow, rd_sel,
    output rd_data, ovf, running
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run/halt control plus cycle and event counters for the
// pipelined MIPS core, with a snapshot bank and a registered read port.
// Counter index 0 is the cycle counter, index k is event counter k-1.
// Optional build macro PERF_SAT_EN: counters saturate at all-ones instead of
// wrapping; the overflow flag sets on the first increment attempt at maximum.
module pipe_perf_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 3
) (
  input logic               clk,
  input logic               rst,
  pipe_perf_monitor_if.slave bus
);

  localparam int NCNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state;
  logic              running;
  logic [NCNT-1:0]   inc;
  logic [NCNT-1:0]   ovf_q;
  logic [CNT_W-1:0]  live   [NCNT];
  logic [CNT_W-1:0]  shadow [NCNT];
  logic [CNT_W-1:0]  rd_next;
  logic [CNT_W-1:0]  rd_q;

  // The pipeline may advance in RUN, or in HALTED while go is held (step/resume)
  always_comb begin
    running = (state == RUN) || bus.go;
  end

  // Per-counter increment requests; freeze only holds the event counters
  always_comb begin
    inc    = '0;
    inc[0] = running;
    for (int i = 0; i < NUM_EVT; i++) begin
      inc[i+1] = running && bus.evt[i] && !bus.freeze;
    end
  end

  // Run/halt FSM: halt without go parks the core, go without halt resumes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (bus.halt && !bus.go) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          if (bus.go && !bus.halt) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Live counters and sticky overflow flags; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int k = 0; k < NCNT; k++) begin
        live[k] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (inc[k]) begin
          if (live[k] == CNT_MAX) begin
            ovf_q[k] <= 1'b1;
`ifdef PERF_SAT_EN
            // Saturating build: the counter simply stays at all-ones
`else
            live[k] <= '0;
`endif
          end else begin
            live[k] <= live[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Snapshot bank captures the pre-edge live values, so snap+clr keeps the old counts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCNT; k++) begin
        shadow[k] <= '0;
      end
    end else if (bus.snap) begin
      for (int k = 0; k < NCNT; k++) begin
        shadow[k] <= live[k];
      end
    end
  end

  // Read mux: selects live or shadow counter, unused select codes read as zero
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (bus.rd_sel == SEL_W'(k)) begin
        rd_next = bus.rd_shadow ? shadow[k] : live[k];
      end
    end
  end

  // Registered read data for the display/LED path
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_next;
    end
  end

  assign bus.running = running;
  assign bus.ovf     = ovf_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: table-driven bench for pipe_perf_monitor, built with
// 8-bit counters so that the overflow corner is reachable. Expected read data
// is queued when a vector is driven and compared when the registered port updates.
module tb_pipe_perf_monitor;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 8;
  localparam int SEL_W   = 3;

`ifdef PERF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_perf_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      tag;
    logic       halt;
    logic       go;
    logic [3:0] evt;
    logic       freeze;
    logic       clr;
    logic       snap;
    logic       rd_shadow;
    logic [2:0] rd_sel;
    logic       exp_running;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic       chk_ovf;
    logic [4:0] exp_ovf;
  } vec_t;

  typedef struct {
    string      tag;
    logic [7:0] rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic add(input string tag, input logic halt, input logic go, input logic [3:0] evt,
                     input logic freeze, input logic clr, input logic snap, input logic rd_shadow,
                     input logic [2:0] rd_sel, input logic exp_running, input logic chk_rd,
                     input logic [7:0] exp_rd, input logic chk_ovf = 1'b0,
                     input logic [4:0] exp_ovf = 5'd0);
    vec_t v;
    v.tag = tag;  v.halt = halt;  v.go = go;  v.evt = evt;  v.freeze = freeze;
    v.clr = clr;  v.snap = snap;  v.rd_shadow = rd_shadow;  v.rd_sel = rd_sel;
    v.exp_running = exp_running;  v.chk_rd = chk_rd;  v.exp_rd = exp_rd;
    v.chk_ovf = chk_ovf;  v.exp_ovf = exp_ovf;
    tbl.push_back(v);
  endtask

  task automatic check_output(input vec_t v);
    exp_t e;
    if (v.chk_rd) begin
      if (sb.size() == 0) begin
        check_value({v.tag, " scoreboard"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_value($sformatf("%s rd_data", e.tag), 32'(bus.rd_data), 32'(e.rd));
      end
    end
    if (v.chk_ovf) begin
      check_value($sformatf("%s ovf", v.tag), 32'(bus.ovf), 32'(v.exp_ovf));
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst           = 1'b0;
    bus.halt      = v.halt;
    bus.go        = v.go;
    bus.evt       = v.evt;
    bus.freeze    = v.freeze;
    bus.clr       = v.clr;
    bus.snap      = v.snap;
    bus.rd_shadow = v.rd_shadow;
    bus.rd_sel    = v.rd_sel;
    #1;
    check_value($sformatf("%s running", v.tag), 32'(bus.running), 32'(v.exp_running));
    if (v.chk_rd) begin
      e.tag = v.tag;
      e.rd  = v.exp_rd;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_output(v);
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply_stimulus(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset(input string tag, input logic [3:0] evt_in, input logic halt_in);
    @(negedge clk);
    rst           = 1'b1;
    bus.halt      = halt_in;
    bus.go        = 1'b0;
    bus.evt       = evt_in;
    bus.freeze    = 1'b0;
    bus.clr       = 1'b0;
    bus.snap      = 1'b0;
    bus.rd_shadow = 1'b0;
    bus.rd_sel    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_value({tag, " running"}, 32'(bus.running), 32'd1);
    check_value({tag, " rd_data"}, 32'(bus.rd_data), 32'd0);
    check_value({tag, " ovf"},     32'(bus.ovf),     32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.halt = 1'b0;  bus.go = 1'b0;  bus.evt = '0;  bus.freeze = 1'b0;
    bus.clr = 1'b0;  bus.snap = 1'b0;  bus.rd_shadow = 1'b0;  bus.rd_sel = '0;

    // Free run: ten cycles with evt=0101, then read every counter back
    do_reset("reset_a", 4'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      add($sformatf("free_%0d", i), 0, 0, 4'b0101, 0, 0, 0, 0, 3'd0, 1, 1, 8'(i));
    add("free_cyc",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd10);
    add("free_evt0", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, 8'd10);
    add("free_evt1", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd2, 1, 1, 8'd0);
    add("free_evt2", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd3, 1, 1, 8'd10);
    add("free_evt3", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd4, 1, 1, 8'd0);
    add("free_sel7", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd7, 1, 1, 8'd0, 1, 5'd0);
    run_table();

    // Halt at cycle 5, hold, then resume with a one-cycle go pulse
    do_reset("reset_b", 4'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      add($sformatf("halt_pre_%0d", i), 0, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 1, 1, 8'(i));
    add("halt_edge",  1, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 1, 1, 8'd5);
    for (int i = 0; i < 3; i++)
      add($sformatf("halted_%0d", i), 1, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 0, 1, 8'd6);
    add("halt_drop",  0, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 0, 1, 8'd6);
    add("resume_go",  0, 1, 4'b0001, 0, 0, 0, 0, 3'd0, 1, 1, 8'd6);
    add("resumed_0",  0, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 1, 1, 8'd7);
    add("resumed_1",  0, 0, 4'b0001, 0, 0, 0, 0, 3'd0, 1, 1, 8'd8);
    add("resume_evt", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, 8'd9);

    // Single step: three separate go pulses while halt stays high
    add("step_halt",  1, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd10);
    add("step_idle0", 1, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 0, 1, 8'd11);
    add("step_go0",   1, 1, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd11);
    add("step_idle1", 1, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 0, 1, 8'd12);
    add("step_go1",   1, 1, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd12);
    add("step_idle2", 1, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 0, 1, 8'd13);
    add("step_go2",   1, 1, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd13);
    add("step_idle3", 1, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 0, 1, 8'd14);
    add("step_hold",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 0, 1, 8'd14);
    run_table();

    // Reset while halted with events and halt asserted: everything returns to zero
    do_reset("reset_halted", 4'hF, 1'b1);
    add("rst_cyc",    0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd0);
    add("rst_evt0",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, 8'd0);
    add("rst_evt1",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd2, 1, 1, 8'd0);
    add("rst_evt2",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd3, 1, 1, 8'd0);
    add("rst_shadow", 0, 0, 4'b0000, 0, 0, 0, 1, 3'd0, 1, 1, 8'd0);

    // Snap and clear together at evt0 = 20
    for (int i = 0; i < 20; i++)
      add($sformatf("snap_cnt_%0d", i), 0, 0, 4'b0001, 0, 0, 0, 0, 3'd1, 1, (i == 10), 8'd10);
    add("snapclr",       0, 0, 4'b0001, 0, 1, 1, 0, 3'd1, 1, 1, 8'd20, 1, 5'd0);
    add("shadow_evt0",   0, 0, 4'b0000, 0, 0, 0, 1, 3'd1, 1, 1, 8'd20);
    add("live_evt0_clr", 0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, 8'd0);
    add("shadow_cyc",    0, 0, 4'b0000, 0, 0, 0, 1, 3'd0, 1, 1, 8'd25);
    add("live_cyc_clr",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd3);

    // Freeze holds event counters but not the cycle counter; out-of-range selects
    add("frz_pre",    0, 0, 4'b0010, 0, 0, 0, 0, 3'd2, 1, 1, 8'd0);
    add("frz_cyc0",   0, 0, 4'b0010, 1, 0, 0, 0, 3'd0, 1, 1, 8'd5);
    for (int i = 0; i < 3; i++)
      add($sformatf("frz_evt1_%0d", i), 0, 0, 4'b0010, 1, 0, 0, 0, 3'd2, 1, 1, 8'd1);
    add("frz_cyc4",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd9);
    add("frz_evt1",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd2, 1, 1, 8'd1);
    add("sel7_live",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd7, 1, 1, 8'd0);
    add("sel5_shad",  0, 0, 4'b0000, 0, 0, 0, 1, 3'd5, 1, 1, 8'd0);
    run_table();

    // Overflow: 256 cycles of evt[0] on 8-bit counters, then clear
    do_reset("reset_g", 4'h0, 1'b0);
    for (int i = 0; i < 256; i++)
      add($sformatf("ovf_%0d", i), 0, 0, 4'b0001, 0, 0, 0, 0, 3'd1, 1, 1, 8'(i),
          (i >= 254), (i == 255) ? 5'b00011 : 5'b00000);
    add("ovf_evt0",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, SAT ? 8'd255 : 8'd0, 1, 5'b00011);
    add("ovf_cyc",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, SAT ? 8'd255 : 8'd1, 1, 5'b00011);
    add("ovf_clr",   0, 0, 4'b0000, 0, 1, 0, 0, 3'd1, 1, 1, SAT ? 8'd255 : 8'd0, 1, 5'b00000);
    add("clr_evt0",  0, 0, 4'b0000, 0, 0, 0, 0, 3'd1, 1, 1, 8'd0, 1, 5'b00000);
    add("clr_cyc",   0, 0, 4'b0000, 0, 0, 0, 0, 3'd0, 1, 1, 8'd1, 1, 5'b00000);
    run_table();

    check_value("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
